// File: rtl/rx_frame_pkg.sv
// Shared definitions for the UART frame receiver.
//   - rx_state_e : parser state encoding (HDR=0, LEN=1, PAY=2, CHK=3)
//   - ERR_*      : frame error cause codes driven on err_code
//   - *_DEFAULT  : default parameter values for the frame controller
//   - width_for  : bits needed to hold the values 0..n-1 (never less than 1)
package rx_frame_pkg;

  typedef enum logic [1:0] {
    StHdr = 2'd0,
    StLen = 2'd1,
    StPay = 2'd2,
    StChk = 2'd3
  } rx_state_e;

  localparam logic [1:0] ERR_LEN = 2'b01;
  localparam logic [1:0] ERR_CHK = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;

  localparam logic [7:0]  HEADER_DEFAULT  = 8'hA5;
  localparam int unsigned MAX_LEN_DEFAULT = 16;
  localparam int unsigned TIMEOUT_DEFAULT = 50000;

  function automatic int unsigned width_for(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rx_frame_ctrl_module_if.sv
// Byte-in / payload-out bundle of the frame controller.
//   enable, rx_done, rx_data           : from the byte receiver side (into the controller)
//   rx_en_sig                          : enable back to the byte receiver
//   pay_valid, pay_data, pay_index     : payload byte stream to the command decoder
//   frame_done, frame_err, err_code    : per-frame status
// The slave modport is the controller's view; master is its environment.
interface rx_frame_ctrl_module_if
  import rx_frame_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEFAULT
) ();

  localparam int unsigned IdxW = width_for(MAX_LEN);

  logic            enable;
  logic            rx_done;
  logic [7:0]      rx_data;
  logic            rx_en_sig;
  logic            pay_valid;
  logic [7:0]      pay_data;
  logic [IdxW-1:0] pay_index;
  logic            frame_done;
  logic            frame_err;
  logic [1:0]      err_code;

  modport master (
    output enable,
    output rx_done,
    output rx_data,
    input  rx_en_sig,
    input  pay_valid,
    input  pay_data,
    input  pay_index,
    input  frame_done,
    input  frame_err,
    input  err_code
  );

  modport slave (
    input  enable,
    input  rx_done,
    input  rx_data,
    output rx_en_sig,
    output pay_valid,
    output pay_data,
    output pay_index,
    output frame_done,
    output frame_err,
    output err_code
  );

endinterface

// File: rtl/rx_gap_timer_module.sv
// Inter-byte gap timer.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : force the count to zero (byte accepted / parser idle / receiver disabled)
//   i_run      : count one per cycle while a frame is in progress
//   o_expire   : combinational pulse in the last allowed idle cycle (count == TIMEOUT_CYC-1)
// A clear in the same cycle masks the pulse, so a byte landing on the expiry cycle wins.
module rx_gap_timer_module
  import rx_frame_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_run,
  output logic o_expire
);

  localparam int unsigned     TmrW    = width_for(TIMEOUT_CYC);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYC - 1);

  logic [TmrW-1:0] r_timer;

  assign o_expire = i_run && !i_clr && (r_timer == TmrLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (i_clr) begin
      r_timer <= '0;
    end else if (i_run && (r_timer != TmrLast)) begin
      // Saturate: the parser leaves the frame on expiry, which clears us next cycle.
      r_timer <= r_timer + 1'b1;
    end
  end

endmodule

// File: rtl/rx_frame_ctrl_module.sv
// Frame controller between the UART byte receiver and the command decoder.
// Parses HEADER, LEN, payload[LEN], CHK frames from the rx_done/rx_data byte stream,
// streams payload bytes with their index, and reports frame success or an error cause.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rx_frame_ctrl_module_if.slave (byte input, payload output, status)
// All outputs are registered: each response appears the cycle after the accepting edge.
// CHK is the XOR of the LEN byte and every payload byte; HEADER is not included.
module rx_frame_ctrl_module
  import rx_frame_pkg::*;
#(
  parameter logic [7:0]  HEADER      = HEADER_DEFAULT,
  parameter int unsigned MAX_LEN     = MAX_LEN_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
  input logic                  clk,
  input logic                  rst_n,
  rx_frame_ctrl_module_if.slave bus
);

  localparam int unsigned IdxW    = width_for(MAX_LEN);
  localparam logic [7:0]  MaxLenB = 8'(MAX_LEN);

  rx_state_e       r_state, w_state_d;
  logic [7:0]      r_len, w_len_d;
  logic [IdxW-1:0] r_cnt, w_cnt_d;
  logic [7:0]      r_chk, w_chk_d;

  logic            r_rx_en;
  logic            r_pay_valid, w_pay_valid_d;
  logic [7:0]      r_pay_data, w_pay_data_d;
  logic [IdxW-1:0] r_pay_index, w_pay_index_d;
  logic            r_frame_done, w_frame_done_d;
  logic            r_frame_err, w_frame_err_d;
  logic [1:0]      r_err_code, w_err_code_d;

  logic            w_accept;
  logic            w_expire;
  logic            w_tmr_clr;
  logic            w_tmr_run;
  logic [7:0]      w_cnt_ext;

  assign w_accept  = bus.rx_done && bus.enable;
  assign w_tmr_run = (r_state != StHdr);
  // Disabling also clears, so a disabled cycle can never raise a timeout.
  assign w_tmr_clr = w_accept || !w_tmr_run || !bus.enable;
  assign w_cnt_ext = 8'(r_cnt);

  rx_gap_timer_module #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_tmr_clr),
    .i_run    (w_tmr_run),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_d      = r_state;
    w_len_d        = r_len;
    w_cnt_d        = r_cnt;
    w_chk_d        = r_chk;
    w_pay_valid_d  = 1'b0;
    w_pay_data_d   = r_pay_data;
    w_pay_index_d  = r_pay_index;
    w_frame_done_d = 1'b0;
    w_frame_err_d  = 1'b0;
    w_err_code_d   = r_err_code;

    if (!bus.enable) begin
      // Silent abort: no status pulse.
      w_state_d = StHdr;
    end else if (w_expire) begin
      w_frame_err_d = 1'b1;
      w_err_code_d  = ERR_TMO;
      w_state_d     = StHdr;
    end else if (w_accept) begin
      unique case (r_state)
        StHdr: begin
          // Non-header bytes are dropped without any report.
          if (bus.rx_data == HEADER) begin
            w_state_d = StLen;
          end
        end
        StLen: begin
          if ((bus.rx_data == 8'd0) || (bus.rx_data > MaxLenB)) begin
            w_frame_err_d = 1'b1;
            w_err_code_d  = ERR_LEN;
            w_state_d     = StHdr;
          end else begin
            w_len_d   = bus.rx_data;
            w_chk_d   = bus.rx_data;
            w_cnt_d   = '0;
            w_state_d = StPay;
          end
        end
        StPay: begin
          w_pay_valid_d = 1'b1;
          w_pay_data_d  = bus.rx_data;
          w_pay_index_d = r_cnt;
          w_chk_d       = r_chk ^ bus.rx_data;
          w_cnt_d       = r_cnt + 1'b1;
          if (w_cnt_ext == (r_len - 8'd1)) begin
            w_state_d = StChk;
          end
        end
        StChk: begin
          if (bus.rx_data == r_chk) begin
            w_frame_done_d = 1'b1;
          end else begin
            w_frame_err_d = 1'b1;
            w_err_code_d  = ERR_CHK;
          end
          w_state_d = StHdr;
        end
        default: w_state_d = StHdr;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StHdr;
      r_len   <= '0;
      r_cnt   <= '0;
      r_chk   <= '0;
    end else begin
      r_state <= w_state_d;
      r_len   <= w_len_d;
      r_cnt   <= w_cnt_d;
      r_chk   <= w_chk_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_en      <= 1'b0;
      r_pay_valid  <= 1'b0;
      r_pay_data   <= '0;
      r_pay_index  <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_code   <= '0;
    end else begin
      r_rx_en      <= bus.enable;
      r_pay_valid  <= w_pay_valid_d;
      r_pay_data   <= w_pay_data_d;
      r_pay_index  <= w_pay_index_d;
      r_frame_done <= w_frame_done_d;
      r_frame_err  <= w_frame_err_d;
      r_err_code   <= w_err_code_d;
    end
  end

  assign bus.rx_en_sig  = r_rx_en;
  assign bus.pay_valid  = r_pay_valid;
  assign bus.pay_data   = r_pay_data;
  assign bus.pay_index  = r_pay_index;
  assign bus.frame_done = r_frame_done;
  assign bus.frame_err  = r_frame_err;
  assign bus.err_code   = r_err_code;

endmodule

// File: tb/tb_rx_frame_ctrl_module.sv
// Scoreboard bench for rx_frame_ctrl_module: a byte-level frame model predicts every
// payload/done/error event with the cycle it must appear in; a monitor pops and compares.
module tb_rx_frame_ctrl_module;

  localparam int unsigned T    = 64;
  localparam int unsigned MAXL = 16;
  localparam logic [7:0]  HDRB = 8'hA5;

  typedef struct {
    int         kind;  // 0 payload, 1 done, 2 error
    int         idx;
    logic [7:0] data;
    logic [1:0] code;
    int         cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_pay = 0, n_done = 0, n_err = 0;
  int   p0, d0, e0;

  ev_t        exp_q[$];
  logic [7:0] frm[$];
  int         last_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rx_frame_ctrl_module_if #(.MAX_LEN(MAXL)) bus ();

  rx_frame_ctrl_module #(
    .HEADER      (HDRB),
    .MAX_LEN     (MAXL),
    .TIMEOUT_CYC (T)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input int got, input int expv);
    n_tests++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  task automatic push(input int k, input int idx, input logic [7:0] d, input logic [1:0] c,
                      input int at);
    ev_t e;
    e.kind = k; e.idx = idx; e.data = d; e.code = c; e.cyc = at;
    exp_q.push_back(e);
  endtask

  // A frame in progress times out if no byte is accepted by edge last_acc+T.
  task automatic model_timeout(input int lim);
    if (frm.size() > 0 && last_acc + int'(T) <= lim) begin
      push(2, 0, 8'h00, 2'b11, last_acc + int'(T));
      frm.delete();
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input int acc);
    int         len;
    logic [7:0] x;
    if (frm.size() == 0) begin
      if (b == HDRB) frm.push_back(b);
    end else begin
      frm.push_back(b);
      len = int'(frm[1]);
      if (frm.size() == 2) begin
        if (len == 0 || len > int'(MAXL)) begin
          push(2, 0, 8'h00, 2'b01, acc);
          frm.delete();
        end
      end else if (frm.size() <= len + 2) begin
        push(0, frm.size() - 3, b, 2'b00, acc);
      end else begin
        x = 8'h00;
        for (int i = 1; i <= len + 1; i++) x = x ^ frm[i];
        if (x == b) push(1, 0, 8'h00, 2'b00, acc);
        else push(2, 0, 8'h00, 2'b10, acc);
        frm.delete();
      end
    end
    last_acc = acc;
  endtask

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int a;
    a = cyc + gap + 1;
    if (bus.enable) model_timeout(a - 1);
    repeat (gap) @(posedge clk);
    #1;
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_done = 1'b0;
    if (bus.enable) model_byte(b, cyc);
  endtask

  task automatic idle(input int n);
    if (bus.enable) model_timeout(cyc + n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int len, input bit corrupt);
    logic [7:0] x, b;
    send_byte(HDRB, $urandom_range(0, 2));
    send_byte(8'(len), $urandom_range(0, 2));
    x = 8'(len);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom_range(0, 255));
      x = x ^ b;
      send_byte(b, $urandom_range(0, 3));
    end
    if (corrupt) x = x ^ 8'($urandom_range(1, 255));
    send_byte(x, $urandom_range(0, 3));
  endtask

  task automatic snap();
    p0 = n_pay; d0 = n_done; e0 = n_err;
  endtask

  function automatic int out_vec();
    return int'({bus.rx_en_sig, bus.pay_valid, bus.pay_data, bus.pay_index, bus.frame_done,
                 bus.frame_err, bus.err_code});
  endfunction

  // Monitor: every status/payload pulse must match the next predicted event.
  always @(negedge clk) begin
    int  k;
    ev_t e;
    bit  ok;
    if (rst_n && (bus.pay_valid || bus.frame_done || bus.frame_err)) begin
      k = bus.pay_valid ? 0 : (bus.frame_done ? 1 : 2);
      if (k == 0) n_pay++;
      else if (k == 1) n_done++;
      else n_err++;
      n_tests++;
      if (int'(bus.pay_valid) + int'(bus.frame_done) + int'(bus.frame_err) != 1) begin
        n_fail++;
        $display("FAIL excl: pv=%0b done=%0b err=%0b at cycle %0d", bus.pay_valid,
                 bus.frame_done, bus.frame_err, cyc);
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected: kind %0d at cycle %0d, none expected", k, cyc);
      end else begin
        e  = exp_q.pop_front();
        ok = (e.kind == k) && (e.cyc == cyc);
        if (k == 0) ok = ok && (e.idx == int'(bus.pay_index)) && (e.data == bus.pay_data);
        if (k == 2) ok = ok && (e.code == bus.err_code);
        if (!ok) begin
          n_fail++;
          $display("FAIL event: got kind %0d idx %0d data %02h code %0d cyc %0d, expected kind %0d idx %0d data %02h code %0d cyc %0d",
                   k, bus.pay_index, bus.pay_data, bus.err_code, cyc,
                   e.kind, e.idx, e.data, e.code, e.cyc);
        end
      end
    end
  end

  initial begin
    #900_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enable  = 1'b0;
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    #1;
    check("reset_outputs", out_vec(), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n      = 1'b1;
    bus.enable = 1'b1;
    @(posedge clk);
    #1;
    check("rx_en_follows", int'(bus.rx_en_sig), 1);

    // Good frame
    snap();
    send_byte(8'hA5, 1); send_byte(8'h03, 1); send_byte(8'h11, 1);
    send_byte(8'h22, 1); send_byte(8'h33, 1); send_byte(8'h03, 1);
    idle(3);
    check("good_pay", n_pay - p0, 3);
    check("good_done", n_done - d0, 1);
    check("good_err", n_err - e0, 0);

    // Bad checksum
    snap();
    send_byte(8'hA5, 1); send_byte(8'h03, 1); send_byte(8'h11, 1);
    send_byte(8'h22, 1); send_byte(8'h33, 1); send_byte(8'h04, 1);
    idle(3);
    check("badchk_pay", n_pay - p0, 3);
    check("badchk_err", n_err - e0, 1);
    check("badchk_done", n_done - d0, 0);
    check("err_code_hold", int'(bus.err_code), 2);

    // Bad lengths, then a short good frame
    snap();
    send_byte(8'hA5, 1); send_byte(8'h00, 1);
    send_byte(8'hA5, 1); send_byte(8'h11, 1);
    send_byte(8'hA5, 1); send_byte(8'h01, 1); send_byte(8'h7E, 1); send_byte(8'h7F, 1);
    idle(3);
    check("badlen_err", n_err - e0, 2);
    check("badlen_done", n_done - d0, 1);

    // Leading garbage
    snap();
    send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h5A, 0);
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h7E, 0); send_byte(8'h7F, 0);
    idle(3);
    check("garbage_pay", n_pay - p0, 1);
    check("garbage_done", n_done - d0, 1);
    check("garbage_err", n_err - e0, 0);

    // Timeout, then a byte landing exactly on the expiry cycle
    snap();
    send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h11, 1);
    idle(T + 5);
    check("tmo_err", n_err - e0, 1);
    check("tmo_code", int'(bus.err_code), 3);
    snap();
    send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h11, 1);
    send_byte(8'h22, T - 1); send_byte(8'h31, 1);
    idle(3);
    check("tmo_edge_err", n_err - e0, 0);
    check("tmo_edge_done", n_done - d0, 1);

    // Enable drop mid-frame
    snap();
    send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h11, 1);
    frm.delete();
    bus.enable = 1'b0;
    check("rx_en_delay_hi", int'(bus.rx_en_sig), 1);
    idle(1);
    check("rx_en_delay_lo", int'(bus.rx_en_sig), 0);
    send_byte(8'hA5, 1);
    idle(2);
    bus.enable = 1'b1;
    idle(1);
    send_byte(8'hA5, 1); send_byte(8'h01, 1); send_byte(8'h55, 1); send_byte(8'h54, 1);
    idle(T + 5);
    check("en_drop_err", n_err - e0, 0);
    check("en_drop_done", n_done - d0, 1);

    // Reset mid-payload
    send_byte(8'hA5, 1); send_byte(8'h03, 1); send_byte(8'h11, 1); send_byte(8'h22, 1);
    idle(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", out_vec(), 0);
    frm.delete();
    check("midreset_sb_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    snap();
    send_byte(8'hA5, 1); send_byte(8'h01, 1); send_byte(8'h7E, 1); send_byte(8'h7F, 1);
    idle(3);
    check("post_reset_done", n_done - d0, 1);

    // Randomized frames
    for (int f = 0; f < 60; f++) begin
      int         kind;
      int         len;
      int         k;
      logic [7:0] b;
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, MAXL);
      case (kind)
        0: begin
          k = $urandom_range(1, 3);
          for (int i = 0; i < k; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == HDRB) b = 8'h00;
            send_byte(b, $urandom_range(0, 2));
          end
          send_frame(len, 1'b0);
        end
        1: begin
          send_byte(HDRB, 1);
          if ($urandom_range(0, 1) == 1) send_byte(8'h00, 1);
          else send_byte(8'($urandom_range(MAXL + 1, 255)), 1);
        end
        2: send_frame(len, 1'b1);
        3: begin
          send_byte(HDRB, 1);
          send_byte(8'(len), 1);
          k = $urandom_range(0, len);
          for (int i = 0; i < k; i++) send_byte(8'($urandom_range(0, 255)), 1);
          idle(T + $urandom_range(0, 4));
        end
        4: begin
          send_byte(HDRB, 1);
          send_byte(8'(len), 1);
          send_byte(8'($urandom_range(0, 255)), T - 1 + $urandom_range(0, 1));
        end
        default: send_frame(len, 1'b0);
      endcase
    end
    idle(T + 5);
    check("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
